// File: rtl/frame_ram_reader_pkg.sv
// Shared constants, FSM state type and a small helper for the frame RAM read path.
package frame_ram_reader_pkg;

    localparam int FRAME_W = 320;
    localparam int FRAME_H = 240;
    localparam int FRAME_S = FRAME_W * FRAME_H;
    localparam int PIX_W   = 8;
    localparam int ADDR_W  = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // A scan counts as busy from the start-accept edge until DONE is reached.
    function automatic logic state_busy(input state_e s);
        return (s == ST_READ) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/frame_ram_reader_if.sv
// RAM port plus pixel stream of the frame reader. Stream rule: a pixel moves on
// every rising edge where m_valid_o && m_ready_i; while valid && !ready the data
// and tags hold, and valid never drops without a transfer.
interface frame_ram_reader_if #(
    parameter int V = 8,
    parameter int A = 20
);
    logic [A-1:0] ram_addr_o;
    logic         ram_we_o;
    logic [V-1:0] ram_data_i;
    logic [V-1:0] m_data_o;
    logic         m_valid_o;
    logic         m_ready_i;
    logic         m_eol_o;
    logic         m_eof_o;

    modport master (
        output ram_addr_o, ram_we_o, m_data_o, m_valid_o, m_eol_o, m_eof_o,
        input  ram_data_i, m_ready_i
    );

    modport slave (
        input  ram_addr_o, ram_we_o, m_data_o, m_valid_o, m_eol_o, m_eof_o,
        output ram_data_i, m_ready_i
    );
endinterface

// File: rtl/frame_ram_reader_skid_fifo2.sv
// Two-entry FIFO; a pop on a full FIFO frees room for a push in the same cycle.
module frame_ram_reader_skid_fifo2 #(
    parameter int WIDTH = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o,
    output logic             empty_o,
    output logic             full_o
);
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = !wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/frame_ram_reader.sv
// Scans the frame RAM from address 0 to S-1 and streams pixels with eol/eof tags,
// using a credit of two (FIFO entries plus the read in flight) to absorb backpressure.
module frame_ram_reader
    import frame_ram_reader_pkg::*;
#(
    parameter int V = PIX_W,
    parameter int S = FRAME_S,
    parameter int A = ADDR_W,
    parameter int W = FRAME_W
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   start_i,
    output logic   busy_o,
    output logic   done_o,
    output state_e dbg_state_o,
    frame_ram_reader_if.master bus
);
    localparam int           CW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [A-1:0] ADDR_LAST = A'(S - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);

    state_e        state_q, state_d;
    logic [A-1:0]  addr_q, addr_d;
    logic [CW-1:0] col_q, col_d;
    logic          inflight_q, inflight_d;
    logic          infl_eol_q, infl_eol_d;
    logic          infl_eof_q, infl_eof_d;

    logic [V+1:0]  fifo_din, fifo_dout;
    logic [1:0]    fifo_count;
    logic          fifo_empty, fifo_full;
    logic          pop, issue, drain_done;
    logic [1:0]    credit_used;

    assign pop         = !fifo_empty && bus.m_ready_i;
    assign credit_used = fifo_count + {1'b0, inflight_q};
    // A pop this cycle returns one credit, so a full credit may still issue.
    assign issue       = (state_q == ST_READ) &&
                         ((credit_used < 2'd2) || (credit_used == 2'd2 && pop));
    assign drain_done  = !inflight_q && (fifo_empty || (pop && !fifo_full));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_READ;
            ST_READ:  if (issue && addr_q == ADDR_LAST) state_d = ST_DRAIN;
            ST_DRAIN: if (drain_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = state_busy(state_q);
        done_o      = (state_q == ST_DONE);
        dbg_state_o = state_q;
    end

    always_comb begin
        addr_d     = addr_q;
        col_d      = col_q;
        inflight_d = issue;
        infl_eol_d = infl_eol_q;
        infl_eof_d = infl_eof_q;
        if (state_q == ST_IDLE || state_q == ST_DONE) begin
            addr_d = '0;
            col_d  = '0;
        end else if (issue) begin
            // The final address is held through DRAIN instead of running past S-1.
            if (addr_q != ADDR_LAST) begin
                addr_d = addr_q + A'(1);
            end
            col_d      = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
            infl_eol_d = (col_q == COL_LAST) || (addr_q == ADDR_LAST);
            infl_eof_d = (addr_q == ADDR_LAST);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q     <= '0;
            col_q      <= '0;
            inflight_q <= 1'b0;
            infl_eol_q <= 1'b0;
            infl_eof_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            col_q      <= col_d;
            inflight_q <= inflight_d;
            infl_eol_q <= infl_eol_d;
            infl_eof_q <= infl_eof_d;
        end
    end

    assign fifo_din = {infl_eol_q, infl_eof_q, bus.ram_data_i};

    frame_ram_reader_skid_fifo2 #(
        .WIDTH (V + 2)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .data_i  (fifo_din),
        .data_o  (fifo_dout),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign bus.ram_addr_o = addr_q;
    assign bus.ram_we_o   = 1'b0;
    assign bus.m_valid_o  = !fifo_empty;
    assign bus.m_eol_o    = fifo_dout[V+1];
    assign bus.m_eof_o    = fifo_dout[V];
    assign bus.m_data_o   = fifo_dout[V-1:0];
endmodule

// File: tb/tb_frame_ram_reader.sv
// Bench for frame_ram_reader on a reduced 32x48 frame: cycle vectors, then whole-frame
// runs under several backpressure patterns, start re-pulses and a mid-frame reset.
module tb_frame_ram_reader;
    import frame_ram_reader_pkg::*;

    localparam int TV = 8;
    localparam int TW = 32;
    localparam int TS = TW * 48;
    localparam int TA = 20;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    logic   busy;
    logic   done;
    state_e dbg_state;

    frame_ram_reader_if #(.V(TV), .A(TA)) bus ();

    frame_ram_reader #(.V(TV), .S(TS), .A(TA), .W(TW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .busy_o      (busy),
        .done_o      (done),
        .dbg_state_o (dbg_state),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Frame RAM preloaded with addr mod 256, registered read.
    always @(posedge clk) bus.ram_data_i <= bus.ram_addr_o[TV-1:0];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [TV+1:0] exp_q[$];
    logic [TV+1:0] got, exp_item, stall_val;
    logic          stall_prev;
    logic          mon_en = 1'b0;
    int hs_cnt, bad_cnt, eol_cnt, eof_cnt, done_cnt, stab_err, we_err, addr_err;
    int last_hs_cyc, done_cyc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.ram_we_o !== 1'b0) we_err++;
            if (bus.ram_addr_o > TA'(TS - 1)) addr_err++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            got = {bus.m_eol_o, bus.m_eof_o, bus.m_data_o};
            if (stall_prev && (!bus.m_valid_o || got !== stall_val)) stab_err++;
            stall_prev = bus.m_valid_o && !bus.m_ready_i;
            stall_val  = got;
            if (bus.m_valid_o && bus.m_ready_i) begin
                if (exp_q.size() == 0) begin
                    bad_cnt++;
                end else begin
                    exp_item = exp_q.pop_front();
                    if (got !== exp_item) bad_cnt++;
                end
                if (hs_cnt == TS - 1) last_hs_cyc = cyc;
                hs_cnt++;
                if (bus.m_eol_o) eol_cnt++;
                if (bus.m_eof_o) eof_cnt++;
            end
        end
    end

    task automatic fill_exp();
        logic       e_eol, e_eof;
        logic [7:0] e_dat;
        exp_q.delete();
        for (int i = 0; i < TS; i++) begin
            e_eof = (i == TS - 1);
            e_eol = ((i % TW) == TW - 1) || e_eof;
            e_dat = 8'(i % 256);
            exp_q.push_back({e_eol, e_eof, e_dat});
        end
    endtask

    task automatic reset_monitor();
        hs_cnt = 0; bad_cnt = 0; eol_cnt = 0; eof_cnt = 0; done_cnt = 0;
        stab_err = 0; we_err = 0; addr_err = 0; last_hs_cyc = -100; done_cyc = -200;
        stall_prev = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high; 1: ready 30% random; 2: 50-cycle stall after first valid;
    // 3: ready high with start re-pulsed at pixel 1000 and on the done cycle.
    task automatic run_frame(input int mode, input string tag);
        bit pulsed = 1'b0;
        fill_exp();
        reset_monitor();
        bus.m_ready_i = (mode == 0 || mode == 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_valid_k"}, bus.m_valid_o, 0);
        tick();
        check({tag, "_valid_k1"}, bus.m_valid_o, 0);
        tick();
        check({tag, "_valid_k2"}, bus.m_valid_o, 1);
        check({tag, "_first_data"}, bus.m_data_o, 0);
        if (mode == 2) begin
            repeat (50) tick();
            check({tag, "_stall_addr"}, bus.ram_addr_o, 2);
            check({tag, "_stall_valid"}, bus.m_valid_o, 1);
            check({tag, "_stall_head"}, bus.m_data_o, 0);
            check({tag, "_stall_hs"}, hs_cnt, 0);
        end
        for (int n = 0; n < 20 * TS; n++) begin
            if (mode == 1) bus.m_ready_i = ($urandom_range(0, 9) < 3);
            else bus.m_ready_i = 1'b1;
            if (mode == 3 && !pulsed && hs_cnt >= 1000) begin
                start  = 1'b1;
                pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                if (mode == 3) start = 1'b1;
                break;
            end
        end
        check({tag, "_busy_on_done"}, busy, 0);
        tick();
        start = 1'b0;
        check({tag, "_state_after_done"}, dbg_state, ST_IDLE);
        check({tag, "_done_one_cycle"}, done, 0);
        repeat (5) tick();
        check({tag, "_no_restart_valid"}, bus.m_valid_o, 0);
        check({tag, "_no_restart_busy"}, busy, 0);
        check({tag, "_idle_addr"}, bus.ram_addr_o, 0);
        mon_en = 1'b0;
        check({tag, "_handshakes"}, hs_cnt, TS);
        check({tag, "_bad_pixels"}, bad_cnt, 0);
        check({tag, "_exp_left"}, exp_q.size(), 0);
        check({tag, "_eol_count"}, eol_cnt, TS / TW);
        check({tag, "_eof_count"}, eof_cnt, 1);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_done_gap"}, done_cyc - last_hs_cyc, 1);
        check({tag, "_stability"}, stab_err, 0);
        check({tag, "_we_high"}, we_err, 0);
        check({tag, "_addr_range"}, addr_err, 0);
    endtask

    typedef struct {
        logic       rst, start, ready;
        logic       busy, done, valid;
        logic [7:0] data;
        int         addr;
        state_e     st;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int done_seen;
        rst = 1'b1;
        start = 1'b0;
        bus.m_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Each row: inputs held across one edge, outputs expected just after it.
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, ST_IDLE};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, ST_IDLE};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 0, ST_READ};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 1, ST_READ};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 2, ST_READ};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 3, ST_READ};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 3, ST_READ};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 3, ST_READ};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 4, ST_READ};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd3, 5, ST_READ};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, ST_IDLE};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 0, ST_IDLE};

        for (int i = 0; i < 12; i++) begin
            rst           = vecs[i].rst;
            start         = vecs[i].start;
            bus.m_ready_i = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("vec%0d_done", i), done, vecs[i].done);
            check($sformatf("vec%0d_valid", i), bus.m_valid_o, vecs[i].valid);
            check($sformatf("vec%0d_data", i), bus.m_data_o, vecs[i].data);
            check($sformatf("vec%0d_eol", i), bus.m_eol_o, 0);
            check($sformatf("vec%0d_eof", i), bus.m_eof_o, 0);
            check($sformatf("vec%0d_addr", i), bus.ram_addr_o, vecs[i].addr);
            check($sformatf("vec%0d_we", i), bus.ram_we_o, 0);
            check($sformatf("vec%0d_state", i), dbg_state, vecs[i].st);
        end
        start = 1'b0;

        run_frame(0, "full_rate");
        run_frame(1, "random_bp");
        run_frame(2, "long_stall");
        run_frame(3, "restart_ignored");

        // Mid-frame reset while stalled: partial frame dropped, no done.
        fill_exp();
        reset_monitor();
        bus.m_ready_i = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 4 * TS; n++) begin
            tick();
            if (hs_cnt >= 500) break;
        end
        bus.m_ready_i = 1'b0;
        check("rst_pre_count", hs_cnt, 500);
        repeat (3) tick();
        mon_en = 1'b0;
        check("rst_pre_valid", bus.m_valid_o, 1);
        check("rst_pre_head", bus.m_data_o, 500 % 256);
        rst = 1'b1;
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", bus.m_valid_o, 0);
        check("rst_data", bus.m_data_o, 0);
        check("rst_eol", bus.m_eol_o, 0);
        check("rst_eof", bus.m_eof_o, 0);
        check("rst_addr", bus.ram_addr_o, 0);
        check("rst_state", dbg_state, ST_IDLE);
        rst = 1'b0;
        bus.m_ready_i = 1'b1;
        done_seen = 0;
        repeat (10) begin
            tick();
            if (done) done_seen++;
        end
        check("rst_no_done", done_seen, 0);
        run_frame(0, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
